// File: rtl/nec_tx_pkg.sv
// Shared definitions for the NEC IR transmitter: FSM state encoding,
// protocol timing in NEC units, and small helpers used by the FSM.
package nec_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned MARK_U       = 1;
  localparam int unsigned ZERO_SPACE_U = 1;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned STOP_U       = 1;
  localparam int unsigned NUM_BITS     = 32;
  localparam int unsigned BIT_IDX_W    = 6;

  // Duration of a state in NEC units; a data space depends on the bit being sent.
  function automatic int unsigned state_units(input state_t s, input logic bit_val,
                                              input int unsigned gap_units);
    case (s)
      LEAD_MARK:  return LEAD_MARK_U;
      LEAD_SPACE: return LEAD_SPACE_U;
      BIT_MARK:   return MARK_U;
      BIT_SPACE:  return bit_val ? ONE_SPACE_U : ZERO_SPACE_U;
      STOP_MARK:  return STOP_U;
      GAP:        return gap_units;
      default:    return 1;
    endcase
  endfunction

  // States in which the IR envelope is a burst.
  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_carrier_gen.sv
// Carrier phase generator for the modulated LED output.
// Ports:
//   clk, rst (sync, active-low)
//   restart  - forces the phase counter to 0 at the next edge (start of a burst)
//   carrier  - carrier level for the cycle following the current edge, derived
//              from the phase register; lets the parent register ir_o in step
//              with the envelope.
module nec_carrier_gen #(
  parameter int unsigned CARRIER_CYC  = 2632,
  parameter int unsigned CARRIER_HIGH = 877
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic carrier
);

  localparam int unsigned CNT_W = $clog2(CARRIER_CYC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next phase: restart wins, otherwise wrap at CARRIER_CYC-1.
  always_comb begin
    cnt_nxt = '0;
    if (!restart && (cnt != CNT_W'(CARRIER_CYC - 1))) begin
      cnt_nxt = cnt + 1'b1;
    end
    carrier = (cnt_nxt < CNT_W'(CARRIER_HIGH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC-protocol IR transmitter: lead mark/space, 32 data bits MSB first,
// stop mark and an optional idle gap.
// Build option: define NEC_TX_CARRIER_EN to modulate ir_o with the carrier;
// otherwise ir_o mirrors env_o and no carrier logic is built.
// Ports:
//   clk, rst (sync, active-low)
//   code  [31:0] frame to send, code[31] first
//   send         start request, sampled only in IDLE
//   busy         high for the whole frame including gap
//   done         one-cycle pulse as busy falls
//   env_o        unmodulated envelope (1 = burst)
//   ir_o         LED drive
module nec_ir_transmitter
  import nec_tx_pkg::*;
#(
  parameter int unsigned UNIT_CYC     = 56250,
  parameter int unsigned GAP_UNITS    = 72,
  parameter int unsigned CARRIER_CYC  = 2632,
  parameter int unsigned CARRIER_HIGH = 877
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] code,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        env_o,
  output logic        ir_o
);

  localparam int unsigned TMR_W  = $clog2(UNIT_CYC);
  localparam int unsigned MAX_U  = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int unsigned UCNT_W = $clog2(MAX_U);
  localparam logic        HAS_GAP = (GAP_UNITS != 0);

  state_t                state;
  logic [TMR_W-1:0]      tmr;
  logic [UCNT_W-1:0]     ucnt;
  logic [NUM_BITS-1:0]   shreg;
  logic [BIT_IDX_W-1:0]  bit_idx;

  int unsigned cur_units_c;
  logic        unit_end_c;
  logic        last_unit_c;
  logic        mark_entry_c;
  logic        env_next_c;
  logic        ir_next_c;

  // Timing decode: end of a unit, end of the current state, and the next envelope level.
  always_comb begin
    cur_units_c  = state_units(state, shreg[NUM_BITS-1], GAP_UNITS);
    unit_end_c   = (tmr == TMR_W'(UNIT_CYC - 1));
    last_unit_c  = unit_end_c && (ucnt == UCNT_W'(cur_units_c - 1));
    // Every mark is entered from IDLE or from a space; marks never follow marks.
    mark_entry_c = ((state == IDLE) && send) ||
                   (last_unit_c && ((state == LEAD_SPACE) || (state == BIT_SPACE)));
    env_next_c   = mark_entry_c || (is_mark(state) && !last_unit_c);
  end

`ifdef NEC_TX_CARRIER_EN
  logic carrier;

  nec_carrier_gen #(
    .CARRIER_CYC  (CARRIER_CYC),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .restart (mark_entry_c),
    .carrier (carrier)
  );

  assign ir_next_c = env_next_c & carrier;
`else
  assign ir_next_c = env_next_c;
`endif

  // Frame sequencer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tmr     <= '0;
      ucnt    <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      env_o   <= 1'b0;
      ir_o    <= 1'b0;
    end else begin
      done  <= 1'b0;
      env_o <= env_next_c;
      ir_o  <= ir_next_c;
      if (state == IDLE) begin
        if (send) begin
          state   <= LEAD_MARK;
          shreg   <= code;
          bit_idx <= '0;
          tmr     <= '0;
          ucnt    <= '0;
          busy    <= 1'b1;
        end
      end else begin
        tmr <= unit_end_c ? '0 : tmr + 1'b1;
        if (unit_end_c) begin
          ucnt <= last_unit_c ? '0 : ucnt + 1'b1;
        end
        if (last_unit_c) begin
          case (state)
            LEAD_MARK:  state <= LEAD_SPACE;
            LEAD_SPACE: state <= BIT_MARK;
            BIT_MARK:   state <= BIT_SPACE;
            BIT_SPACE: begin
              shreg   <= {shreg[NUM_BITS-2:0], 1'b0};
              bit_idx <= bit_idx + 1'b1;
              state   <= (bit_idx == BIT_IDX_W'(NUM_BITS - 1)) ? STOP_MARK : BIT_MARK;
            end
            STOP_MARK: begin
              if (HAS_GAP) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
            GAP: begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter with a small unit time
// (UNIT_CYC=4, GAP_UNITS=8, carrier period 6 with 2 high cycles).
module tb_nec_ir_transmitter;

  localparam int unsigned UNIT  = 4;
  localparam int          MAXN  = 1200;
  localparam logic [31:0] CODE_A = 32'h00FF10EF;
  localparam logic [31:0] CODE_B = 32'h12345678;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] code;
  logic        send;
  logic        busy;
  logic        done;
  logic        env_o;
  logic        ir_o;

  int checks = 0;
  int passed = 0;

  logic busy_tr [0:MAXN-1];
  logic done_tr [0:MAXN-1];
  logic env_tr  [0:MAXN-1];
  logic ir_tr   [0:MAXN-1];
  logic exp_env [0:MAXN-1];
  int   mptr;

  nec_ir_transmitter #(
    .UNIT_CYC     (4),
    .GAP_UNITS    (8),
    .CARRIER_CYC  (6),
    .CARRIER_HIGH (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .code  (code),
    .send  (send),
    .busy  (busy),
    .done  (done),
    .env_o (env_o),
    .ir_o  (ir_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Start a frame and record outputs for n cycles; index 0 is the first cycle after acceptance.
  task automatic capture(input logic [31:0] c, input int n, input int send_until,
                         input int inject_at, input logic [31:0] inj_code);
    @(negedge clk);
    code = c;
    send = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i >= send_until) send = 1'b0;
      if (i == inject_at) begin
        send = 1'b1;
        code = inj_code;
      end
      busy_tr[i] = busy;
      done_tr[i] = done;
      env_tr[i]  = env_o;
      ir_tr[i]   = ir_o;
      @(negedge clk);
    end
    send = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXN; i++) exp_env[i] = 1'b0;
  endtask

  task automatic put(input logic v, input int units);
    for (int j = 0; j < units * int'(UNIT); j++) begin
      if (mptr < MAXN) exp_env[mptr] = v;
      mptr++;
    end
  endtask

  // Reference envelope built directly from the NEC timing rules.
  task automatic build_model(input logic [31:0] c, input int offset);
    mptr = offset;
    put(1'b1, 16);
    put(1'b0, 8);
    for (int k = 0; k < 32; k++) begin
      put(1'b1, 1);
      put(1'b0, c[31-k] ? 3 : 1);
    end
    put(1'b1, 1);
    put(1'b0, 8);
  endtask

  function automatic int busy_run(input int start, input int n);
    int r = 0;
    for (int i = start; i < n; i++) begin
      if (!busy_tr[i]) return r;
      r++;
    end
    return r;
  endfunction

  function automatic int done_count(input int start, input int n);
    int r = 0;
    for (int i = start; i < n; i++) if (done_tr[i]) r++;
    return r;
  endfunction

  function automatic int env_mismatches(input int n);
    int r = 0;
    for (int i = 0; i < n; i++) if (env_tr[i] !== exp_env[i]) r++;
    return r;
  endfunction

  // Expected LED drive derived from the reference envelope.
  function automatic int ir_mismatches(input int n);
    int r = 0;
    int pos = 0;
    logic e;
    for (int i = 0; i < n; i++) begin
      if (exp_env[i] && (i == 0 || !exp_env[i-1])) pos = 0;
`ifdef NEC_TX_CARRIER_EN
      e = exp_env[i] && ((pos % 6) < 2);
`else
      e = exp_env[i];
`endif
      if (ir_tr[i] !== e) r++;
      pos++;
    end
    return r;
  endfunction

  // Recover the data bits from a recorded envelope by measuring space widths.
  function automatic logic [31:0] decode_trace(input int start, input int n);
    int i = start;
    int run;
    logic [31:0] r = '0;
    while (i < n && env_tr[i]) i++;
    while (i < n && !env_tr[i]) i++;
    for (int k = 0; k < 32; k++) begin
      while (i < n && env_tr[i]) i++;
      run = 0;
      while (i < n && !env_tr[i]) begin
        run++;
        i++;
      end
      r = {r[30:0], 1'(run > 8)};
    end
    return r;
  endfunction

  task automatic test_reset();
    rst  = 1'b0;
    send = 1'b1;
    code = CODE_A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, env_o, ir_o} !== 4'b0000)
        $display("FAIL reset_hold[%0d]: got %b expected 0000", i, {busy, done, env_o, ir_o});
      else passed++;
    end
    send = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, env_o, ir_o} !== 4'b0000)
        $display("FAIL reset_release[%0d]: got %b expected 0000", i, {busy, done, env_o, ir_o});
      else passed++;
    end
  endtask

  task automatic test_frame();
    int b;
    capture(CODE_A, 700, 0, -1, '0);
    clear_model();
    build_model(CODE_A, 0);
    b = busy_run(0, 700);
    checks++;
    if (b != 516 || busy_tr[516] !== 1'b0) $display("FAIL frame_busy_len: got %0d expected 516", b);
    else passed++;
    checks++;
    if (done_count(0, 700) != 1 || done_tr[516] !== 1'b1)
      $display("FAIL frame_done: got count %0d done@516=%b expected 1 pulse at 516",
               done_count(0, 700), done_tr[516]);
    else passed++;
    b = 0;
    for (int i = 0; i < 64; i++) if (env_tr[i] === 1'b1) b++;
    checks++;
    if (b != 64) $display("FAIL lead_mark: got %0d high cycles expected 64", b);
    else passed++;
    b = 0;
    for (int i = 64; i < 96; i++) if (env_tr[i] === 1'b0) b++;
    checks++;
    if (b != 32 || env_tr[96] !== 1'b1) $display("FAIL lead_space: got %0d low cycles expected 32", b);
    else passed++;
    checks++;
    if (decode_trace(0, 700) !== CODE_A)
      $display("FAIL frame_bits: got %h expected %h", decode_trace(0, 700), CODE_A);
    else passed++;
    checks++;
    if (env_mismatches(700) != 0) $display("FAIL frame_env: got %0d mismatching cycles expected 0", env_mismatches(700));
    else passed++;
    checks++;
    if (ir_mismatches(700) != 0) $display("FAIL frame_ir: got %0d mismatching cycles expected 0", ir_mismatches(700));
    else passed++;
  endtask

  task automatic test_lengths();
    logic [31:0] codes [2];
    int          lens  [2];
    int          b;
    codes[0] = 32'h0000_0000; lens[0] = 388;
    codes[1] = 32'hFFFF_FFFF; lens[1] = 644;
    for (int t = 0; t < 2; t++) begin
      capture(codes[t], 700, 0, -1, '0);
      clear_model();
      build_model(codes[t], 0);
      b = busy_run(0, 700);
      checks++;
      if (b != lens[t]) $display("FAIL len_busy[%h]: got %0d expected %0d", codes[t], b, lens[t]);
      else passed++;
      checks++;
      if (done_count(0, 700) != 1 || done_tr[lens[t]] !== 1'b1)
        $display("FAIL len_done[%h]: got count %0d expected 1 at %0d", codes[t], done_count(0, 700), lens[t]);
      else passed++;
      checks++;
      if (env_mismatches(700) != 0 || ir_mismatches(700) != 0)
        $display("FAIL len_wave[%h]: got env %0d ir %0d mismatches expected 0",
                 codes[t], env_mismatches(700), ir_mismatches(700));
      else passed++;
    end
  endtask

  task automatic test_ignore_send();
    int b;
    capture(CODE_A, 700, 0, 100, CODE_B);
    clear_model();
    build_model(CODE_A, 0);
    b = busy_run(0, 700);
    checks++;
    if (b != 516 || busy_run(517, 700) != 0) $display("FAIL ignore_busy: got %0d expected 516 and no refire", b);
    else passed++;
    checks++;
    if (decode_trace(0, 700) !== CODE_A)
      $display("FAIL ignore_bits: got %h expected %h", decode_trace(0, 700), CODE_A);
    else passed++;
    checks++;
    if (env_mismatches(700) != 0) $display("FAIL ignore_env: got %0d mismatching cycles expected 0", env_mismatches(700));
    else passed++;
  endtask

  task automatic test_back_to_back();
    capture(CODE_A, 1100, 520, -1, '0);
    clear_model();
    build_model(CODE_A, 0);
    build_model(CODE_A, 517);
    checks++;
    if (done_tr[516] !== 1'b1 || busy_tr[516] !== 1'b0 || env_tr[516] !== 1'b0)
      $display("FAIL b2b_done: got done %b busy %b env %b expected 1 0 0",
               done_tr[516], busy_tr[516], env_tr[516]);
    else passed++;
    checks++;
    if (env_tr[517] !== 1'b1 || busy_tr[517] !== 1'b1)
      $display("FAIL b2b_restart: got env %b busy %b expected 1 1", env_tr[517], busy_tr[517]);
    else passed++;
    checks++;
    if (busy_run(517, 1100) != 516 || done_count(0, 1100) != 2)
      $display("FAIL b2b_second: got busy %0d dones %0d expected 516 2",
               busy_run(517, 1100), done_count(0, 1100));
    else passed++;
    checks++;
    if (env_mismatches(1100) != 0 || decode_trace(517, 1100) !== CODE_A)
      $display("FAIL b2b_wave: got %0d mismatches bits %h expected 0 %h",
               env_mismatches(1100), decode_trace(517, 1100), CODE_A);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int dn;
    int bz;
    int b;
    @(negedge clk);
    code = CODE_A;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    // Bit 10 of 00FF10EF is a one; its space covers cycles 196..207.
    repeat (200) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || env_o !== 1'b0) $display("FAIL mid_pre: got busy %b env %b expected 1 0", busy, env_o);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, env_o, ir_o} !== 4'b0000)
      $display("FAIL mid_reset: got %b expected 0000", {busy, done, env_o, ir_o});
    else passed++;
    rst = 1'b1;
    dn = 0;
    bz = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    checks++;
    if (dn != 0 || bz != 0) $display("FAIL mid_abandon: got done %0d busy %0d expected 0 0", dn, bz);
    else passed++;
    capture(32'h0, 700, 0, -1, '0);
    clear_model();
    build_model(32'h0, 0);
    b = busy_run(0, 700);
    checks++;
    if (b != 388 || env_mismatches(700) != 0 || done_count(0, 700) != 1)
      $display("FAIL mid_clean: got busy %0d env mism %0d dones %0d expected 388 0 1",
               b, env_mismatches(700), done_count(0, 700));
    else passed++;
  endtask

  initial begin
    rst  = 1'b0;
    send = 1'b0;
    code = '0;
    test_reset();
    test_frame();
    test_lengths();
    test_ignore_send();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
